// File: rtl/lagarto_dcache_arbiter.sv
// Lagarto dcache arbiter: shares the blocking L1 dcache port among N_REQ
// requesters (0 = PTW fixed priority, 1..N_REQ-1 round-robin).
// Ports: clk_i/rstn_i; rq_* requester side (valid/kill/payload in,
// gnt/rs_valid/rs_err out, rs_data); mem_req_* to dcache; mem_resp_* back.
module lagarto_dcache_arbiter #(
  parameter int N_REQ     = 3,
  parameter int ADDR_W    = 64,
  parameter int MAX_RETRY = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [N_REQ-1:0]        rq_valid_i,
  input  logic [N_REQ-1:0]        rq_kill_i,
  input  logic [N_REQ*ADDR_W-1:0] rq_addr_i,
  input  logic [N_REQ*64-1:0]     rq_wdata_i,
  input  logic [N_REQ-1:0]        rq_we_i,
  input  logic [N_REQ*8-1:0]      rq_be_i,
  input  logic [N_REQ*2-1:0]      rq_size_i,
  output logic [N_REQ-1:0]        rq_gnt_o,
  output logic [N_REQ-1:0]        rs_valid_o,
  output logic [N_REQ-1:0]        rs_err_o,
  output logic [63:0]             rs_data_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDR_W-1:0]       mem_req_addr_o,
  output logic [63:0]             mem_req_wdata_o,
  output logic                    mem_req_we_o,
  output logic [7:0]              mem_req_be_o,
  output logic [1:0]              mem_req_size_o,
  output logic                    mem_req_kill_o,
  input  logic                    mem_resp_valid_i,
  input  logic                    mem_resp_nack_i,
  input  logic [63:0]             mem_resp_data_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [IW-1:0] LAST  = IW'(N_REQ-1);
  localparam logic [RW-1:0] RLAST = RW'(MAX_RETRY-1);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_WAIT, S_DRAIN
  } state_e;

  state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [7:0] be_q, be_d;
  logic [1:0] size_q, size_d;

  logic win_v, hi_v;
  logic [IW-1:0] win, hi_idx, lo_idx;
  logic [N_REQ-1:0] win_oh, own_oh;
  logic kill_own;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0] sel_wdata;
  logic sel_we;
  logic [7:0] sel_be;
  logic [1:0] sel_size;

  // Round-robin: lowest valid index at/after rr_q, else lowest valid
  // overall (the wrap back to 1). Index 0 overrides both.
  always_comb begin
    hi_v   = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = N_REQ-1; i >= 1; i--) begin
      if (rq_valid_i[i]) begin
        lo_idx = IW'(i);
        if (IW'(i) >= rr_q) begin
          hi_v   = 1'b1;
          hi_idx = IW'(i);
        end
      end
    end
    win_v = |rq_valid_i;
    if (rq_valid_i[0]) win = '0;
    else if (hi_v)     win = hi_idx;
    else               win = lo_idx;
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_size  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        sel_addr  = rq_addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = rq_wdata_i[i*64 +: 64];
        sel_we    = rq_we_i[i];
        sel_be    = rq_be_i[i*8 +: 8];
        sel_size  = rq_size_i[i*2 +: 2];
      end
    end
  end

  assign win_oh   = N_REQ'(1) << win;
  assign own_oh   = N_REQ'(1) << owner_q;
  assign kill_own = |(rq_kill_i & own_oh);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      rr_q    <= IW'(1);
      owner_q <= '0;
      retry_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    be_d    = be_q;
    size_d  = size_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_v) begin
          state_d = S_REQ;
          owner_d = win;
          retry_d = '0;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          we_d    = sel_we;
          be_d    = sel_be;
          size_d  = sel_size;
          if (!rq_valid_i[0])
            rr_d = (win == LAST) ? IW'(1) : win + IW'(1);
        end
      end
      S_REQ: begin
        if (kill_own)             state_d = S_IDLE;
        else if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          if (kill_own || !mem_resp_nack_i || retry_q == RLAST) begin
            state_d = S_IDLE;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = S_REQ;
          end
        end else if (kill_own) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rq_gnt_o        = '0;
    rs_valid_o      = '0;
    rs_err_o        = '0;
    mem_req_valid_o = 1'b0;
    mem_req_kill_o  = 1'b0;
    unique case (state_q)
      S_IDLE: rq_gnt_o = win_v ? win_oh : '0;
      S_REQ:  mem_req_valid_o = 1'b1;
      S_WAIT: begin
        if (mem_resp_valid_i && !kill_own) begin
          if (!mem_resp_nack_i)    rs_valid_o = own_oh;
          else if (retry_q == RLAST) rs_err_o = own_oh;
        end else if (!mem_resp_valid_i && kill_own) begin
          mem_req_kill_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rs_data_o       = mem_resp_data_i;
  assign mem_req_addr_o  = addr_q;
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_we_o    = we_q;
  assign mem_req_be_o    = be_q;
  assign mem_req_size_o  = size_q;

  // A response with no request outstanding breaks the dcache protocol.
  a_resp_proto: assert property (
    @(posedge clk_i) disable iff (!rstn_i)
    mem_resp_valid_i |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_lagarto_dcache_arbiter.sv
// Directed bench for lagarto_dcache_arbiter.
// Inputs driven 1ns after posedge, outputs sampled 2ns later.
module tb_lagarto_dcache_arbiter;
  localparam int N = 3;

  logic clk_i = 1'b0;
  logic rstn_i;
  logic [N-1:0] rq_valid_i, rq_kill_i, rq_we_i;
  logic [N*64-1:0] rq_addr_i, rq_wdata_i;
  logic [N*8-1:0] rq_be_i;
  logic [N*2-1:0] rq_size_i;
  logic [N-1:0] rq_gnt_o, rs_valid_o, rs_err_o;
  logic [63:0] rs_data_o;
  logic mem_req_valid_o, mem_req_ready_i;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic mem_req_we_o, mem_req_kill_o;
  logic [7:0] mem_req_be_o;
  logic [1:0] mem_req_size_o;
  logic mem_resp_valid_i, mem_resp_nack_i;
  logic [63:0] mem_resp_data_i;

  int total = 0;
  int bad = 0;

  lagarto_dcache_arbiter #(.N_REQ(3), .ADDR_W(64), .MAX_RETRY(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .rq_valid_i(rq_valid_i), .rq_kill_i(rq_kill_i),
    .rq_addr_i(rq_addr_i), .rq_wdata_i(rq_wdata_i),
    .rq_we_i(rq_we_i), .rq_be_i(rq_be_i), .rq_size_i(rq_size_i),
    .rq_gnt_o(rq_gnt_o), .rs_valid_o(rs_valid_o),
    .rs_err_o(rs_err_o), .rs_data_o(rs_data_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o),
    .mem_req_we_o(mem_req_we_o), .mem_req_be_o(mem_req_be_o),
    .mem_req_size_o(mem_req_size_o),
    .mem_req_kill_o(mem_req_kill_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_nack_i(mem_resp_nack_i),
    .mem_resp_data_i(mem_resp_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Full transaction expected to be granted to requester w.
  task automatic txn(input int w, input logic [63:0] d);
    logic [2:0] oh;
    oh = 3'b001 << w;
    #2;
    chk("gnt", 64'(rq_gnt_o), 64'(oh));
    tick();
    mem_req_ready_i = 1'b1;
    #2;
    chk("mvalid", 64'(mem_req_valid_o), 64'd1);
    chk("maddr", mem_req_addr_o, rq_addr_i[w*64 +: 64]);
    tick();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = d;
    #2;
    chk("rsvalid", 64'(rs_valid_o), 64'(oh));
    chk("rsdata", rs_data_o, d);
    tick();
    mem_resp_valid_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0;
    rq_valid_i = '0;
    rq_kill_i = '0;
    rq_we_i = '0;
    rq_addr_i = {64'h3000, 64'h2000, 64'h1000};
    rq_wdata_i = '0;
    rq_be_i = '0;
    rq_size_i = '0;
    mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_nack_i = 1'b0;
    mem_resp_data_i = '0;
    repeat (2) tick();
    #2;
    chk("rst_gnt", 64'(rq_gnt_o), 64'd0);
    chk("rst_mvalid", 64'(mem_req_valid_o), 64'd0);
    chk("rst_maddr", mem_req_addr_o, 64'd0);
    chk("rst_mkill", 64'(mem_req_kill_o), 64'd0);
    chk("rst_rsv", 64'(rs_valid_o), 64'd0);
    chk("rst_err", 64'(rs_err_o), 64'd0);
    rstn_i = 1'b1;
    tick();

    // PTW priority, then 1/2 alternation
    rq_valid_i = 3'b111;
    txn(0, 64'hA0);
    txn(0, 64'hA1);
    rq_valid_i = 3'b110;
    txn(1, 64'hB1);
    txn(2, 64'hB2);
    txn(1, 64'hB3);
    txn(2, 64'hB4);

    // Load
    rq_valid_i = 3'b010;
    rq_addr_i[64 +: 64] = 64'h8000_1000;
    rq_size_i[2 +: 2] = 2'b11;
    txn(1, 64'hDEADBEEF_CAFEF00D);
    chk("ld_size", 64'(mem_req_size_o), 64'd3);

    // Store nacked 3x then acked
    rq_valid_i = 3'b100;
    rq_we_i[2] = 1'b1;
    rq_wdata_i[128 +: 64] = 64'h1122_3344_5566_7788;
    rq_be_i[16 +: 8] = 8'hF0;
    #2;
    chk("st_gnt", 64'(rq_gnt_o), 64'h4);
    tick();
    rq_valid_i = '0;
    for (int n = 0; n < 4; n++) begin
      mem_req_ready_i = 1'b1;
      #2;
      chk("st_mvalid", 64'(mem_req_valid_o), 64'd1);
      tick();
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_resp_nack_i  = (n < 3);
      #2;
      chk("st_rsv", 64'(rs_valid_o), (n == 3) ? 64'h4 : 64'h0);
      chk("st_err", 64'(rs_err_o), 64'd0);
      tick();
      mem_resp_valid_i = 1'b0;
      mem_resp_nack_i  = 1'b0;
    end
    #2;
    chk("st_idle", 64'(mem_req_valid_o), 64'd0);
    chk("st_wdata", mem_req_wdata_o, 64'h1122_3344_5566_7788);
    chk("st_we", 64'(mem_req_we_o), 64'd1);
    chk("st_be", 64'(mem_req_be_o), 64'hF0);
    tick();

    // Retries exhausted on the load, store granted next
    rq_valid_i = 3'b110;
    #2;
    chk("ex_gnt", 64'(rq_gnt_o), 64'h2);
    tick();
    for (int n = 0; n < 4; n++) begin
      mem_req_ready_i = 1'b1;
      #2;
      chk("ex_mvalid", 64'(mem_req_valid_o), 64'd1);
      tick();
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_resp_nack_i  = 1'b1;
      #2;
      chk("ex_err", 64'(rs_err_o), (n == 3) ? 64'h2 : 64'h0);
      chk("ex_rsv", 64'(rs_valid_o), 64'd0);
      chk("ex_gnt0", 64'(rq_gnt_o), 64'd0);
      tick();
      mem_resp_valid_i = 1'b0;
      mem_resp_nack_i  = 1'b0;
    end
    txn(2, 64'hC2);

    // Kill in WAIT, late response drained
    rq_valid_i = 3'b010;
    #2;
    chk("kw_gnt", 64'(rq_gnt_o), 64'h2);
    tick();
    rq_valid_i = '0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    rq_kill_i = 3'b010;
    #2;
    chk("kw_mkill", 64'(mem_req_kill_o), 64'd1);
    chk("kw_rsv", 64'(rs_valid_o), 64'd0);
    tick();
    rq_kill_i = '0;
    rq_valid_i = 3'b100;
    for (int n = 0; n < 4; n++) begin
      #2;
      chk("dr_mkill", 64'(mem_req_kill_o), 64'd0);
      chk("dr_gnt", 64'(rq_gnt_o), 64'd0);
      tick();
    end
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 64'h5A5A;
    #2;
    chk("dr_rsv", 64'(rs_valid_o), 64'd0);
    chk("dr_gntr", 64'(rq_gnt_o), 64'd0);
    tick();
    mem_resp_valid_i = 1'b0;
    #2;
    chk("dr_idle", 64'(rq_gnt_o), 64'h4);

    // Kill in REQ beats ready
    tick();
    rq_valid_i = '0;
    rq_kill_i = 3'b100;
    mem_req_ready_i = 1'b1;
    #2;
    chk("kr_mkill", 64'(mem_req_kill_o), 64'd0);
    chk("kr_mvalid", 64'(mem_req_valid_o), 64'd1);
    tick();
    rq_kill_i = '0;
    mem_req_ready_i = 1'b0;
    rq_valid_i = 3'b010;
    txn(1, 64'hD1);

    // Async reset while in WAIT
    rq_valid_i = 3'b010;
    #2;
    chk("ar_gnt", 64'(rq_gnt_o), 64'h2);
    tick();
    rq_valid_i = '0;
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    #2;
    rstn_i = 1'b0;
    #1;
    chk("ar_mvalid", 64'(mem_req_valid_o), 64'd0);
    chk("ar_maddr", mem_req_addr_o, 64'd0);
    chk("ar_msize", 64'(mem_req_size_o), 64'd0);
    chk("ar_rsv", 64'(rs_valid_o), 64'd0);
    chk("ar_err", 64'(rs_err_o), 64'd0);
    chk("ar_gnt0", 64'(rq_gnt_o), 64'd0);
    tick();
    tick();
    rstn_i = 1'b1;
    rq_valid_i = 3'b110;
    txn(1, 64'hE1);
    rq_valid_i = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
